load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-side stage directly downstream of the single-cycle core's ALU/store-data path.
- Replaces the core's zero-latency data memory port with a handshaked, multi-cycle memory interface.
- Converts the core's byte-addressed load/store request (address, funct3, store data) into word-aligned bus transactions with byte strobes.
- Stalls the core until the access completes, then returns sign-/zero-extended load data for register write-back.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT without mem_ack before abort with bus_error.
- COUNT_W, 8, width of the timeout counter; must satisfy 2^COUNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_read  input  1  load request from the core, held stable while core_stall=1.
- core_write  input  1  store request from the core, held stable while core_stall=1.
- core_funct3  input  3  access size/sign; instruction[14:12].
- core_addr  input  32  byte address; ALU result.
- core_wdata  input  32  store data; rs2 value.
- core_rdata  output  32  extended load data, valid in the DONE cycle.
- core_stall  output  1  freezes PC and register write while high.
- access_fault  output  1  misaligned or illegal request, combinational.
- bus_error  output  1  high in the DONE cycle of a timed-out access.
- mem_req  output  1  bus request, registered.
- mem_we  output  1  1 = write, 0 = read, registered.
- mem_addr  output  32  word address {addr[31:2],2'b00}, registered.
- mem_wdata  output  32  lane-replicated store data, registered.
- mem_wstrb  output  4  byte enables; 4'b0000 on reads.
- mem_ack  input  1  single-cycle completion pulse from memory.
- mem_rdata  input  32  read word, valid with mem_ack.

Behaviour:
- Reset (async): state=IDLE, counter=0. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, core_rdata=0, bus_error=0. core_stall and access_fault follow their combinational definitions.
- States: IDLE, WAIT, DONE.
- Fault check (combinational), access_fault=1 when the request is valid (read or write) and any of the following holds:
  - core_read and core_write both high.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- A faulting request never leaves IDLE: no bus request, core_stall=0, core_rdata=0.
- IDLE:
  - core_stall = (core_read|core_write) & ~access_fault.
  - When stalling, register request fields, assert mem_req, go to WAIT on the next edge.
- WAIT:
  - core_stall=1. mem_req held high, all bus outputs held stable.
  - Counter increments each cycle.
  - mem_ack=1: capture extended data into core_rdata, drop mem_req, go DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: drop mem_req, core_rdata=0, set bus_error, go DONE.
  - If ack and timeout coincide, ack wins.
- DONE:
  - core_stall=0; the core commits this cycle.
  - Go to IDLE unconditionally on the next edge; never re-issues the still-present request.
  - bus_error cleared on exit; counter cleared.
- Latency: request seen in cycle N → mem_req high from N+1 → ack in cycle M → DONE in M+1.
  - Minimum total stall is 2 cycles (ack in N+1, DONE in N+2).
- Store lanes:
  - SB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1]?1100:0011.
  - SW: wstrb=1111.
- Load extraction uses byte lane addr[1:0] / half addr[1]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Load/store result is written into core_rdata only; stores leave core_rdata=0.
- mem_ack outside WAIT is ignored.
- Reset mid-WAIT: mem_req drops asynchronously; the transaction is abandoned.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req → stall 4 cycles total, DONE core_rdata=0xDEADBEEF, mem_wstrb=0000, mem_addr=0x100.
- LB addr=0x103 and LBU addr=0x103 with mem_rdata=0x80112233 → core_rdata=0xFFFFFF80 and 0x00000080 respectively.
- SH addr=0x202, wdata=0x1234ABCD → mem_we=1, mem_wdata=0xABCDABCD, mem_wstrb=1100, mem_addr=0x200.
- LW addr=0x101; SH addr=0x3; read and write asserted together → each gives access_fault=1, core_stall=0, mem_req never asserted.
- TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 WAIT cycles, DONE with bus_error=1, core_rdata=0, back to IDLE the next cycle.
- Reset pulsed 2 cycles into WAIT → mem_req=0 immediately. After release, state is IDLE; a new LW completes normally with stray late ack ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns the core's byte-addressed load/store requests into
// handshaked word-aligned bus transactions and stalls the core until they finish.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        access_fault,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // The counter holds the number of WAIT cycles already spent, so the
    // abort happens in the WAIT cycle where it equals TIMEOUT_CYCLES-1.
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [COUNT_W-1:0] count_reg;
    logic [2:0]         funct3_reg;
    logic [1:0]         lane_reg;
    logic [31:0]        rdata_reg;
    logic               bus_error_reg;
    logic               mem_req_reg, mem_we_reg;
    logic [31:0]        mem_addr_reg, mem_wdata_reg;
    logic [3:0]         mem_wstrb_reg;

    logic        req_valid, load_ok, store_ok, misaligned, fault;
    logic        stall;
    logic [3:0]  strb_comb;
    logic [31:0] wdata_comb, load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign req_valid = core_read | core_write;

    always_comb begin
        load_ok    = core_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok   = core_funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned = ((core_funct3[1:0] == 2'b01) && core_addr[0]) ||
                     ((core_funct3[1:0] == 2'b10) && (core_addr[1:0] != 2'b00));
        fault      = req_valid && ((core_read && core_write) ||
                                   (core_read && !load_ok) ||
                                   (core_write && !store_ok) ||
                                   misaligned);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign strb_comb[gi] = (core_funct3[1:0] == 2'b10) ||
                               ((core_funct3[1:0] == 2'b01) && (core_addr[1] == 1'(gi >> 1))) ||
                               ((core_funct3[1:0] == 2'b00) && (core_addr[1:0] == 2'(gi)));
    end

    always_comb begin
        case (core_funct3[1:0])
            2'b00:   wdata_comb = {4{core_wdata[7:0]}};
            2'b01:   wdata_comb = {2{core_wdata[15:0]}};
            default: wdata_comb = core_wdata;
        endcase
    end

    always_comb begin
        load_byte = mem_rdata[{lane_reg, 3'b000} +: 8];
        load_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_reg)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = req_valid & ~fault;
                if (stall) state_next = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_ack || (count_reg == LAST_COUNT)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            funct3_reg    <= 3'd0;
            lane_reg      <= 2'd0;
            rdata_reg     <= 32'd0;
            bus_error_reg <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wstrb_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (state_next == WAIT) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= core_write;
                        mem_addr_reg  <= {core_addr[31:2], 2'b00};
                        mem_wdata_reg <= wdata_comb;
                        mem_wstrb_reg <= core_write ? strb_comb : 4'b0000;
                        funct3_reg    <= core_funct3;
                        lane_reg      <= core_addr[1:0];
                    end
                end
                WAIT: begin
                    count_reg <= count_reg + 1'b1;
                    // Ack takes priority over a coinciding timeout.
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        rdata_reg   <= mem_we_reg ? 32'd0 : load_data;
                    end else if (count_reg == LAST_COUNT) begin
                        mem_req_reg   <= 1'b0;
                        rdata_reg     <= 32'd0;
                        bus_error_reg <= 1'b1;
                    end
                end
                DONE: begin
                    count_reg     <= '0;
                    bus_error_reg <= 1'b0;
                    rdata_reg     <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign core_rdata   = rdata_reg;
    assign core_stall   = stall;
    assign access_fault = fault;
    assign bus_error    = bus_error_reg;
    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_wstrb    = mem_wstrb_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus and
// completion records; negedge monitors pop and compare when the DUT presents them.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_read, core_write;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall, access_fault, bus_error;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(4), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .core_read(core_read), .core_write(core_write), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_stall(core_stall), .access_fault(access_fault), .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_wdata;
    } bus_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];
    int    check_count = 0;
    int    pass_count  = 0;
    logic  prev_stall  = 1'b0;
    logic  prev_req    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_count++;
    endtask

    // Bus monitor: compare request fields on each rising mem_req.
    // Completion monitor: compare result on each stall release.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
            prev_req   <= 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, b.we});
                    check("mem_addr", mem_addr, b.addr);
                    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
                    if (b.chk_wdata) check("mem_wdata", mem_wdata, b.wdata);
                end
            end
            if (prev_stall && !core_stall) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    $display("done: rdata=%h bus_error=%b (expected %h/%b)",
                             core_rdata, bus_error, d.rdata, d.err);
                    check("core_rdata", core_rdata, d.rdata);
                    check("bus_error", {31'd0, bus_error}, {31'd0, d.err});
                end
            end
            prev_req   <= mem_req;
            prev_stall <= core_stall;
        end
    end

    // ack_at: WAIT cycle (1-based) in which mem_ack is pulsed; 0 = never.
    task automatic run_access(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                              input int exp_stall);
        int   k;
        int   cycles;
        logic done;
        bus_t  b;
        done_t d;
        @(posedge clk); #1;
        core_read = r; core_write = w; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        b.we = w; b.addr = {addr[31:2], 2'b00}; b.wdata = exp_wdata; b.strb = exp_strb;
        b.chk_wdata = w;
        bus_q.push_back(b);
        d.rdata = exp_rdata; d.err = exp_err;
        done_q.push_back(d);
        #1;
        check("access_fault_ok", {31'd0, access_fault}, 32'd0);
        check("stall_request", {31'd0, core_stall}, 32'd1);
        cycles = 1; k = 1; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (!core_stall) begin
                done = 1'b1;
                mem_ack = 1'b0;
                check("mem_req_done", {31'd0, mem_req}, 32'd0);
            end else begin
                cycles++;
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rd : 32'h5A5A5A5A;
                k++;
            end
        end
        if (!done) check("done_reached", 32'd0, 32'd1);
        check("stall_cycles", 32'(cycles), 32'(exp_stall));
        $display("access r=%b w=%b f3=%b addr=%h stall_cycles=%0d", r, w, f3, addr, cycles);
        @(posedge clk); #1;
        core_read = 1'b0; core_write = 1'b0;
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        check("idle_rdata", core_rdata, 32'd0);
    endtask

    task automatic run_fault(input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] addr);
        @(posedge clk); #1;
        core_read = r; core_write = w; core_funct3 = f3; core_addr = addr;
        core_wdata = 32'h1234ABCD;
        #1;
        check("access_fault", {31'd0, access_fault}, 32'd1);
        check("fault_stall", {31'd0, core_stall}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("fault_mem_req", {31'd0, mem_req}, 32'd0);
            check("fault_rdata", core_rdata, 32'd0);
        end
        $display("fault r=%b w=%b f3=%b addr=%h access_fault=%b", r, w, f3, addr, access_fault);
        @(posedge clk); #1;
        core_read = 1'b0; core_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        core_read = 1'b0; core_write = 1'b0; core_funct3 = 3'd0;
        core_addr = 32'd0; core_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);
        check("rst_core_stall", {31'd0, core_stall}, 32'd0);

        //          r     w     f3      addr          wdata          mem_rdata      ack exp_rdata      err   strb     exp_wdata      stall
        run_access(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,         32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0,         4);
        run_access(1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,         32'h80112233, 1, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0,         2);
        run_access(1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,         32'h80112233, 2, 32'h00000080, 1'b0, 4'b0000, 32'h0,         3);
        run_access(1'b0, 1'b1, 3'b001, 32'h00000202, 32'h1234ABCD,  32'hFFFFFFFF, 1, 32'h00000000, 1'b0, 4'b1100, 32'hABCDABCD, 2);
        run_access(1'b0, 1'b1, 3'b000, 32'h00000001, 32'h000000A5,  32'hFFFFFFFF, 1, 32'h00000000, 1'b0, 4'b0010, 32'hA5A5A5A5, 2);
        run_access(1'b0, 1'b1, 3'b010, 32'h00000030, 32'hCAFEF00D,  32'hFFFFFFFF, 2, 32'h00000000, 1'b0, 4'b1111, 32'hCAFEF00D, 3);
        run_access(1'b1, 1'b0, 3'b001, 32'h00000402, 32'h0,         32'h80017FFF, 1, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0,         2);
        run_access(1'b1, 1'b0, 3'b101, 32'h00000400, 32'h0,         32'h8001F234, 1, 32'h0000F234, 1'b0, 4'b0000, 32'h0,         2);
        run_access(1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,         32'h00007F00, 1, 32'h0000007F, 1'b0, 4'b0000, 32'h0,         2);
        // No ack: abort after 4 WAIT cycles with bus_error.
        run_access(1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0,         32'h0,         0, 32'h00000000, 1'b1, 4'b0000, 32'h0,         5);
        // Ack in the last WAIT cycle beats the timeout.
        run_access(1'b1, 1'b0, 3'b010, 32'h00000504, 32'h0,         32'h12345678, 4, 32'h12345678, 1'b0, 4'b0000, 32'h0,         5);

        run_fault(1'b1, 1'b0, 3'b010, 32'h00000101);
        run_fault(1'b0, 1'b1, 3'b001, 32'h00000003);
        run_fault(1'b1, 1'b1, 3'b010, 32'h00000000);
        run_fault(1'b1, 1'b0, 3'b011, 32'h00000000);
        run_fault(1'b0, 1'b1, 3'b100, 32'h00000000);

        // Reset two cycles into WAIT abandons the transaction.
        begin
            bus_t b;
            @(posedge clk); #1;
            core_read = 1'b1; core_write = 1'b0; core_funct3 = 3'b010; core_addr = 32'h00000600;
            b.we = 1'b0; b.addr = 32'h00000600; b.wdata = 32'h0; b.strb = 4'b0000; b.chk_wdata = 1'b0;
            bus_q.push_back(b);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
            #2 reset = 1'b1; core_read = 1'b0;
            #1;
            check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("async_rst_stall", {31'd0, core_stall}, 32'd0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
            check("post_rst_bus_error", {31'd0, bus_error}, 32'd0);
            $display("reset mid-WAIT: mem_req=%b core_stall=%b", mem_req, core_stall);
            @(posedge clk); #1;
            mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            check("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
            check("stray_ack_stall", {31'd0, core_stall}, 32'd0);
            check("stray_ack_rdata", core_rdata, 32'd0);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h00000700, 32'h0, 32'h0BADF00D, 2, 32'h0BADF00D, 1'b0, 4'b0000, 32'h0, 3);

        repeat (3) @(posedge clk);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
